// File: rtl/keypad_code_entry.sv
// keypad_code_entry: debounced keypad passcode entry (clk, rst, key_press, key_code in; keypad_out, code_ok, code_bad, locked, digit_cnt out)
module keypad_code_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CODE_LEN = 4,
  parameter logic [15:0] PASSCODE = 16'h1234,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
  parameter int unsigned MAX_FAIL = 3,
  parameter logic [31:0] LOCKOUT_CYCLES = 32'd3_000_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_press,
  input  logic [3:0] key_code,
  output logic [3:0] keypad_out,
  output logic       code_ok,
  output logic       code_bad,
  output logic       locked,
  output logic [2:0] digit_cnt
);
  localparam int BW = 4 * CODE_LEN;
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_CHECK, S_LOCKOUT} state_t;
  state_t r_state, w_next;
  logic r_kp_s1, r_kp_s2, r_db_lvl, r_evt;
  logic [3:0] r_kc_s1, r_kc_s2, r_key;
  logic [31:0] r_db_cnt, r_to_cnt, r_lo_cnt;
  logic [BW-1:0] r_buf;
  logic [7:0] r_fail;
  logic [2:0] r_digit_cnt;
  logic r_code_ok, r_code_bad, r_locked;
  logic w_digit, w_clear, w_timeout, w_match, w_last, w_lo_done, w_full;
  logic w_code_ok, w_code_bad, w_locked;
  logic [2:0] w_dcnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_kp_s1 <= 1'b0;
      r_kp_s2 <= 1'b0;
      r_kc_s1 <= '0;
      r_kc_s2 <= '0;
      r_db_lvl <= 1'b0;
      r_db_cnt <= '0;
      r_evt <= 1'b0;
      r_key <= '0;
    end else begin
      r_kp_s1 <= key_press;
      r_kp_s2 <= r_kp_s1;
      r_kc_s1 <= key_code;
      r_kc_s2 <= r_kc_s1;
      r_evt <= 1'b0;
      if (r_kp_s2 == r_db_lvl)
        r_db_cnt <= '0;
      else if (r_db_cnt == DEBOUNCE_CYCLES) begin
        r_db_lvl <= r_kp_s2;
        r_db_cnt <= '0;
        r_evt <= r_kp_s2;
        r_key <= r_kc_s2;
      end else
        r_db_cnt <= r_db_cnt + 32'd1;
    end
  assign w_digit = r_evt && r_key <= 4'd9;
  assign w_clear = r_evt && r_key == 4'hE;
  assign w_timeout = r_state == S_COLLECT && r_to_cnt == TIMEOUT_CYCLES - 1;
  assign w_match = r_buf == PASSCODE[BW-1:0];
  assign w_last = r_fail == 8'(MAX_FAIL - 1);
  assign w_lo_done = r_lo_cnt == LOCKOUT_CYCLES - 32'd1;
  assign w_full = r_digit_cnt == 3'(CODE_LEN - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  // timeout is evaluated ahead of key handling so an expiring digit is dropped
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = w_digit ? (CODE_LEN == 1 ? S_CHECK : S_COLLECT) : S_IDLE;
      S_COLLECT: w_next = (w_timeout || w_clear) ? S_IDLE : (w_digit && w_full) ? S_CHECK : S_COLLECT;
      S_CHECK:   w_next = (!w_match && w_last) ? S_LOCKOUT : S_IDLE;
      S_LOCKOUT: w_next = w_lo_done ? S_IDLE : S_LOCKOUT;
      default:   w_next = S_IDLE;
    endcase
  end
  always_comb begin
    w_code_ok = r_state == S_CHECK && w_match;
    w_code_bad = r_state == S_CHECK && !w_match;
    w_locked = w_next == S_LOCKOUT;
    w_dcnt = r_state == S_IDLE ? (w_digit ? 3'd1 : 3'd0) :
             r_state == S_COLLECT ? ((w_timeout || w_clear) ? 3'd0 : w_digit ? r_digit_cnt + 3'd1 : r_digit_cnt) : 3'd0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_buf <= '0;
      r_fail <= '0;
      r_to_cnt <= '0;
      r_lo_cnt <= '0;
      r_digit_cnt <= '0;
      r_code_ok <= 1'b0;
      r_code_bad <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_buf <= r_state == S_IDLE ? (w_digit ? BW'(r_key) : '0) :
               r_state == S_COLLECT ? ((w_timeout || w_clear) ? '0 : w_digit ? BW'({r_buf, r_key}) : r_buf) : '0;
      r_fail <= r_state == S_CHECK ? (w_match ? 8'd0 : r_fail + 8'd1) :
                (r_state == S_LOCKOUT && w_lo_done) ? 8'd0 : r_fail;
      r_to_cnt <= (r_state == S_COLLECT && w_next == S_COLLECT && !w_digit) ? r_to_cnt + 32'd1 : '0;
      r_lo_cnt <= (r_state == S_LOCKOUT && !w_lo_done) ? r_lo_cnt + 32'd1 : '0;
      r_digit_cnt <= w_dcnt;
      r_code_ok <= w_code_ok;
      r_code_bad <= w_code_bad;
      r_locked <= w_locked;
    end
  assign keypad_out = r_code_ok ? 4'b1100 : 4'b0000;
  assign code_ok = r_code_ok;
  assign code_bad = r_code_bad;
  assign locked = r_locked;
  assign digit_cnt = r_digit_cnt;
endmodule

// File: tb/tb_keypad_code_entry.sv
// tb_keypad_code_entry: table, hand-sequence and randomized model checks of keypad_code_entry
module tb_keypad_code_entry;
  localparam int D = 4;
  localparam int T = 50;
  localparam int L = 100;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_press = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [3:0] keypad_out;
  logic code_ok, code_bad, locked;
  logic [2:0] digit_cnt;
  int tests = 0;
  int fails = 0;
  int n_ok = 0;
  int n_bad = 0;
  int lock_cycles = 0;
  logic prev_ok = 1'b0;
  logic prev_bad = 1'b0;
  logic last_bad_locked = 1'b0;
  typedef struct {
    logic [3:0] key;
    int dc;
    int ok;
    int bad;
    int lk;
  } vec_t;
  vec_t tbl[$];
  int mq[$];
  int mfail = 0;
  bit mlock = 1'b0;
  keypad_code_entry #(
    .DEBOUNCE_CYCLES(D), .CODE_LEN(4), .PASSCODE(16'h1234),
    .TIMEOUT_CYCLES(T), .MAX_FAIL(3), .LOCKOUT_CYCLES(32'd100)
  ) dut (
    .clk(clk), .rst(rst), .key_press(key_press), .key_code(key_code),
    .keypad_out(keypad_out), .code_ok(code_ok), .code_bad(code_bad),
    .locked(locked), .digit_cnt(digit_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (code_ok) begin
        n_ok++;
        check("ok_width", prev_ok, 0);
      end
      if (code_bad) begin
        n_bad++;
        last_bad_locked = locked;
        check("bad_width", prev_bad, 0);
      end
      if (locked) lock_cycles++;
      check("keypad_out", keypad_out, code_ok ? 4'hC : 4'h0);
      prev_ok = code_ok;
      prev_bad = code_bad;
    end
  endtask
  task automatic press(input logic [3:0] k);
    key_code = k;
    key_press = 1'b1;
    cyc(10);
    key_press = 1'b0;
    cyc(10);
  endtask
  task automatic add(input logic [3:0] k, input int dc, input int ok, input int bad, input int lk);
    vec_t v;
    v.key = k; v.dc = dc; v.ok = ok; v.bad = bad; v.lk = lk;
    tbl.push_back(v);
  endtask
  task automatic model(input logic [3:0] k, output int ok, output int bad);
    int v;
    ok = 0;
    bad = 0;
    v = 0;
    if (k <= 4'd9) begin
      mq.push_back(int'(k));
      if (mq.size() == 4) begin
        foreach (mq[i]) v = v * 16 + mq[i];
        if (v == 'h1234) begin
          ok = 1;
          mfail = 0;
        end else begin
          bad = 1;
          mfail++;
          if (mfail == 3) mlock = 1'b1;
        end
        mq.delete();
      end
    end else if (k == 4'hE) mq.delete();
  endtask
  task automatic wait_unlock;
    for (int i = 0; i < 200 && locked; i++) cyc(1);
    check("unlock", locked, 0);
  endtask
  task automatic code(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) press(c[4*i +: 4]);
  endtask
  initial begin
    int o, b, eok, ebad;
    logic [3:0] k;
    cyc(3);
    check("rst_kout", keypad_out, 0);
    check("rst_ok", code_ok, 0);
    check("rst_bad", code_bad, 0);
    check("rst_locked", locked, 0);
    check("rst_dc", digit_cnt, 0);
    rst = 1'b0;
    cyc(2);
    press(4'h1);
    press(4'h2);
    press(4'h3);
    o = n_ok;
    key_code = 4'h4;
    key_press = 1'b1;
    cyc(D + 4);
    check("lat_check_dc", digit_cnt, 4);
    check("lat_early_ok", code_ok, 0);
    cyc(1);
    check("lat_ok", code_ok, 1);
    check("lat_kout", keypad_out, 4'hC);
    check("lat_dc0", digit_cnt, 0);
    cyc(1);
    check("lat_ok_fall", code_ok, 0);
    cyc(3);
    key_press = 1'b0;
    cyc(10);
    check("lat_ok_count", n_ok - o, 1);
    add(4'h1, 1, 0, 0, 0); add(4'h2, 2, 0, 0, 0); add(4'h3, 3, 0, 0, 0); add(4'h4, 0, 1, 0, 0);
    add(4'h1, 1, 0, 0, 0); add(4'h2, 2, 0, 0, 0); add(4'hE, 0, 0, 0, 0); add(4'hA, 0, 0, 0, 0);
    add(4'h1, 1, 0, 0, 0); add(4'h2, 2, 0, 0, 0); add(4'h3, 3, 0, 0, 0); add(4'h4, 0, 1, 0, 0);
    for (int r = 0; r < 3; r++) begin
      add(4'h1, 1, 0, 0, 0); add(4'h2, 2, 0, 0, 0); add(4'h3, 3, 0, 0, 0); add(4'h5, 0, 0, 1, r == 2);
    end
    lock_cycles = 0;
    foreach (tbl[i]) begin
      o = n_ok;
      b = n_bad;
      press(tbl[i].key);
      check($sformatf("tbl%0d_dc", i), digit_cnt, tbl[i].dc);
      check($sformatf("tbl%0d_ok", i), n_ok - o, tbl[i].ok);
      check($sformatf("tbl%0d_bad", i), n_bad - b, tbl[i].bad);
      check($sformatf("tbl%0d_locked", i), locked, tbl[i].lk);
    end
    check("lock_with_bad", last_bad_locked, 1);
    o = n_ok;
    code(16'h1234);
    check("lockout_ignore_ok", n_ok - o, 0);
    check("lockout_ignore_dc", digit_cnt, 0);
    check("lockout_still", locked, 1);
    wait_unlock;
    check("lockout_len", lock_cycles, L);
    o = n_ok;
    code(16'h1234);
    check("post_lock_ok", n_ok - o, 1);
    press(4'h1);
    press(4'h2);
    check("to_dc2", digit_cnt, 2);
    cyc(T - 13);
    check("to_before", digit_cnt, 2);
    cyc(1);
    check("to_expire", digit_cnt, 0);
    b = n_bad;
    code(16'h3412);
    check("to_restart_bad", n_bad - b, 1);
    key_code = 4'h1;
    for (int i = 0; i < 3; i++) begin
      key_press = 1'b1;
      cyc(1);
      key_press = 1'b0;
      cyc(1);
    end
    key_press = 1'b1;
    cyc(30);
    key_press = 1'b0;
    cyc(10);
    check("bounce_dc", digit_cnt, 1);
    press(4'hE);
    check("clear_dc", digit_cnt, 0);
    code(16'h1234);
    for (int r = 0; r < 3; r++) code(16'h1235);
    check("rl_locked", locked, 1);
    rst = 1'b1;
    #2;
    check("rl_locked0", locked, 0);
    check("rl_dc", digit_cnt, 0);
    check("rl_ok", code_ok, 0);
    check("rl_bad", code_bad, 0);
    check("rl_kout", keypad_out, 0);
    cyc(2);
    rst = 1'b0;
    cyc(2);
    o = n_ok;
    code(16'h1234);
    check("rl_code_ok", n_ok - o, 1);
    check("rl_unlocked", locked, 0);
    for (int it = 0; it < 60; it++) begin
      k = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'(mq.size() + 1);
      model(k, eok, ebad);
      o = n_ok;
      b = n_bad;
      press(k);
      check("rnd_dc", digit_cnt, mq.size());
      check("rnd_ok", n_ok - o, eok);
      check("rnd_bad", n_bad - b, ebad);
      check("rnd_locked", locked, mlock);
      if (mlock) begin
        wait_unlock;
        mlock = 1'b0;
        mfail = 0;
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
